// File: rtl/weight_update.sv
// weight_update: gradient-descent write-back of the layer-1 and layer-2 weight words in the shared RAM.
// Optional feature: define WEIGHT_UPDATE_SATURATE_EN to clamp updated weights instead of wrapping them.
module weight_update #(
  parameter int WWIDTH   = 8,
  parameter int LR_SHIFT = 4,
  parameter int ADDR_L0  = 0,
  parameter int ADDR_L1  = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic signed [8:0]  x0,
  input  logic signed [8:0]  x1,
  input  logic signed [8:0]  x2,
  input  logic signed [8:0]  x3,
  input  logic signed [8:0]  v0,
  input  logic signed [8:0]  v1,
  input  logic signed [8:0]  v2,
  input  logic signed [8:0]  v3,
  input  logic signed [8:0]  v4,
  input  logic signed [8:0]  v5,
  input  logic signed [8:0]  delta_20,
  input  logic signed [8:0]  delta_21,
  input  logic signed [8:0]  delta_22,
  input  logic signed [8:0]  delta_23,
  input  logic signed [8:0]  delta_24,
  input  logic signed [8:0]  delta_25,
  input  logic signed [8:0]  delta_30,
  input  logic signed [8:0]  delta_31,
  output logic               busy,
  output logic               done,
  output logic [3:0]         addr,
  output logic [255:0]       write_data,
  output logic               we,
  input  logic [255:0]       read_data
);

  localparam int DW     = ((WWIDTH > 18) ? WWIDTH : 18) + 1;
  localparam int WMAX_I = (1 << (WWIDTH - 1)) - 1;
  localparam int WMIN_I = -(1 << (WWIDTH - 1));

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RD0   = 4'd1,
    S_WAIT0 = 4'd2,
    S_UPD0  = 4'd3,
    S_WR0   = 4'd4,
    S_RD1   = 4'd5,
    S_WAIT1 = 4'd6,
    S_UPD1  = 4'd7,
    S_WR1   = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  state_t                   state_q, state_d;
  logic [4:0]               k_q, k_d;
  logic [255:0]             wbuf_q, wbuf_d;
  logic signed [8:0]        x_q  [4];
  logic signed [8:0]        v_q  [6];
  logic signed [8:0]        d2_q [6];
  logic signed [8:0]        d3_q [2];

  logic [3:0]               addr_q, addr_d;
  logic                     we_q, we_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [255:0]             wdata_q, wdata_d;

  logic signed [8:0]        a_s, d_s;
  logic [2:0]               hid_s;
  logic signed [17:0]       prod_s, shift_s;
  logic signed [WWIDTH-1:0] wgt_s;
  logic signed [DW-1:0]     diff_s;
  logic [WWIDTH-1:0]        new_w_s;

  function automatic logic [WWIDTH-1:0] reduce_w(input logic signed [DW-1:0] v);
    logic [WWIDTH-1:0] r;
`ifdef WEIGHT_UPDATE_SATURATE_EN
    if (v > DW'(WMAX_I)) begin
      r = WWIDTH'(WMAX_I);
    end else if (v < DW'(WMIN_I)) begin
      r = WWIDTH'(WMIN_I);
    end else begin
      r = v[WWIDTH-1:0];
    end
`else
    r = v[WWIDTH-1:0];
`endif
    return r;
  endfunction

  // State, counter and working buffer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      k_q     <= 5'd0;
      wbuf_q  <= 256'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wbuf_q  <= wbuf_d;
    end
  end

  // Operand snapshot taken when a pass is accepted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) x_q[i] <= 9'sd0;
      for (int i = 0; i < 6; i++) begin
        v_q[i]  <= 9'sd0;
        d2_q[i] <= 9'sd0;
      end
      d3_q[0] <= 9'sd0;
      d3_q[1] <= 9'sd0;
    end else if ((state_q == S_IDLE) && start) begin
      x_q  <= '{x0, x1, x2, x3};
      v_q  <= '{v0, v1, v2, v3, v4, v5};
      d2_q <= '{delta_20, delta_21, delta_22, delta_23, delta_24, delta_25};
      d3_q <= '{delta_30, delta_31};
    end
  end

  // Operand selection and per-weight update arithmetic
  always_comb begin
    a_s   = 9'sd0;
    d_s   = 9'sd0;
    hid_s = 3'd0;
    case (state_q)
      S_UPD0: begin
        a_s = x_q[k_q[1:0]];
        d_s = d2_q[k_q[4:2]];
      end
      S_UPD1: begin
        if (k_q < 5'd6) begin
          hid_s = k_q[2:0];
          d_s   = d3_q[0];
        end else begin
          hid_s = k_q[2:0] - 3'd6;  // k=6..11 wraps modulo 8 onto 0..5
          d_s   = d3_q[1];
        end
        a_s = v_q[hid_s];
      end
      default: begin
        a_s = 9'sd0;
        d_s = 9'sd0;
      end
    endcase
    prod_s  = 18'(a_s) * 18'(d_s);
    shift_s = prod_s >>> LR_SHIFT;
    wgt_s   = wbuf_q[k_q*WWIDTH +: WWIDTH];
    diff_s  = DW'(wgt_s) - DW'(shift_s);
    new_w_s = reduce_w(diff_s);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wbuf_d  = wbuf_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RD0;
        else       state_d = S_IDLE;
      end
      S_RD0:   state_d = S_WAIT0;
      S_WAIT0: begin
        wbuf_d  = read_data;
        state_d = S_UPD0;
      end
      S_UPD0: begin
        wbuf_d[k_q*WWIDTH +: WWIDTH] = new_w_s;
        if (k_q == 5'd23) begin
          k_d     = 5'd0;
          state_d = S_WR0;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      S_WR0:   state_d = S_RD1;
      S_RD1:   state_d = S_WAIT1;
      S_WAIT1: begin
        wbuf_d  = read_data;
        state_d = S_UPD1;
      end
      S_UPD1: begin
        wbuf_d[k_q*WWIDTH +: WWIDTH] = new_w_s;
        if (k_q == 5'd11) begin
          k_d     = 5'd0;
          state_d = S_WR1;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      S_WR1:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the upcoming state, registered below
  always_comb begin
    addr_d  = 4'd0;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    wdata_d = wdata_q;
    case (state_d)
      S_RD0, S_WAIT0, S_UPD0: begin
        addr_d = 4'(ADDR_L0);
        busy_d = 1'b1;
      end
      S_WR0: begin
        addr_d  = 4'(ADDR_L0);
        busy_d  = 1'b1;
        we_d    = 1'b1;
        wdata_d = wbuf_d;
      end
      S_RD1, S_WAIT1, S_UPD1: begin
        addr_d = 4'(ADDR_L1);
        busy_d = 1'b1;
      end
      S_WR1: begin
        addr_d  = 4'(ADDR_L1);
        busy_d  = 1'b1;
        we_d    = 1'b1;
        wdata_d = wbuf_d;
      end
      S_DONE:  done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= 4'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wdata_q <= 256'd0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wdata_q <= wdata_d;
    end
  end

  assign addr       = addr_q;
  assign we         = we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign write_data = wdata_q;

endmodule

// File: tb/tb_weight_update.sv
// Bench for weight_update: RAM model plus a per-weight arithmetic reference model.
module tb_weight_update;

  localparam int LR = 4;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               start = 1'b0;
  logic signed [8:0]  xr  [4];
  logic signed [8:0]  vr  [6];
  logic signed [8:0]  d2r [6];
  logic signed [8:0]  d3r [2];
  logic               busy, done, we;
  logic [3:0]         addr;
  logic [255:0]       write_data;
  logic [255:0]       read_data = 256'd0;
  logic [255:0]       mem [16];

  int sx [4];
  int sv [6];
  int sd2 [6];
  int sd3 [2];
  int total = 0;
  int bad = 0;

  weight_update #(.WWIDTH(8), .LR_SHIFT(LR), .ADDR_L0(0), .ADDR_L1(1)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .x0(xr[0]), .x1(xr[1]), .x2(xr[2]), .x3(xr[3]),
    .v0(vr[0]), .v1(vr[1]), .v2(vr[2]), .v3(vr[3]), .v4(vr[4]), .v5(vr[5]),
    .delta_20(d2r[0]), .delta_21(d2r[1]), .delta_22(d2r[2]),
    .delta_23(d2r[3]), .delta_24(d2r[4]), .delta_25(d2r[5]),
    .delta_30(d3r[0]), .delta_31(d3r[1]),
    .busy(busy), .done(done), .addr(addr), .write_data(write_data),
    .we(we), .read_data(read_data)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read RAM shared with the DUT
  always @(posedge CLK) begin
    read_data <= mem[addr];
    if (we) mem[addr] <= write_data;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic zero_ops();
    for (int i = 0; i < 4; i++) xr[i] = 9'sd0;
    for (int i = 0; i < 6; i++) begin
      vr[i]  = 9'sd0;
      d2r[i] = 9'sd0;
    end
    d3r[0] = 9'sd0;
    d3r[1] = 9'sd0;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) xr[i] = 9'($urandom_range(0, 511));
    for (int i = 0; i < 6; i++) begin
      vr[i]  = 9'($urandom_range(0, 511));
      d2r[i] = 9'($urandom_range(0, 511));
    end
    d3r[0] = 9'($urandom_range(0, 511));
    d3r[1] = 9'($urandom_range(0, 511));
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // Reference: w_new = w - floor(a*d / 2^LR), then wrap or clamp to 8 bits
  function automatic logic [255:0] model_word(input logic [255:0] w, input int layer);
    logic [255:0] r;
    int n, wv, a, d, p, res;
    r = w;
    n = (layer == 0) ? 24 : 12;
    for (int k = 0; k < n; k++) begin
      wv = $signed(w[k*8 +: 8]);
      if (layer == 0) begin
        a = sx[k % 4];
        d = sd2[k / 4];
      end else begin
        a = sv[k % 6];
        d = sd3[k / 6];
      end
      p = a * d;
      res = wv - (p >>> LR);
`ifdef WEIGHT_UPDATE_SATURATE_EN
      if (res > 127) res = 127;
      else if (res < -128) res = -128;
`endif
      r[k*8 +: 8] = res[7:0];
    end
    return r;
  endfunction

  // mode 0: plain pass, 1: second start at cycle 5, 2: reset at cycle 30
  task automatic do_pass(input int mode, input string nm);
    logic [255:0] pre0, pre1, e0, e1;
    logic [255:0] wr_d [2];
    logic [3:0]   wr_a [2];
    int wr_at [2];
    int busy_n, we_n, done_n, done_at;
    busy_n = 0; we_n = 0; done_n = 0; done_at = -1;
    wr_at[0] = -1; wr_at[1] = -1;
    wr_d[0] = '0; wr_d[1] = '0; wr_a[0] = '0; wr_a[1] = '0;
    for (int i = 0; i < 4; i++) sx[i] = xr[i];
    for (int i = 0; i < 6; i++) begin
      sv[i]  = vr[i];
      sd2[i] = d2r[i];
    end
    sd3[0] = d3r[0];
    sd3[1] = d3r[1];
    pre0 = mem[0];
    pre1 = mem[1];
    e0 = model_word(pre0, 0);
    e1 = model_word(pre1, 1);
    @(negedge CLK);
    start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge CLK);
      #1;
      if (!RST) begin
        if (busy) busy_n++;
        if (we) begin
          if (we_n < 2) begin
            wr_at[we_n] = c;
            wr_d[we_n]  = write_data;
            wr_a[we_n]  = addr;
          end
          we_n++;
        end
        if (done) begin
          done_n++;
          done_at = c;
        end
      end
      start = (mode == 1) && (c == 4);
      if (c == 0 || (mode == 1 && c == 4)) rand_ops();
      if (mode == 2 && c == 29) begin
        RST = 1'b1;
        #1;
        chk({nm, "_rst_we"}, 256'(we), 256'd0);
        chk({nm, "_rst_busy"}, 256'(busy), 256'd0);
      end
      if (mode == 2 && c == 33) RST = 1'b0;
    end
    if (mode == 2) begin
      chk({nm, "_we_count"}, 256'(we_n), 256'd1);
      chk({nm, "_done_count"}, 256'(done_n), 256'd0);
      chk({nm, "_wr0_data"}, wr_d[0], e0);
      chk({nm, "_mem0"}, mem[0], e0);
      chk({nm, "_mem1_untouched"}, mem[1], pre1);
    end else begin
      chk({nm, "_busy_cycles"}, 256'(busy_n), 256'd42);
      chk({nm, "_we_count"}, 256'(we_n), 256'd2);
      chk({nm, "_wr0_at"}, 256'(wr_at[0] + 1), 256'd27);
      chk({nm, "_wr1_at"}, 256'(wr_at[1] + 1), 256'd42);
      chk({nm, "_done_count"}, 256'(done_n), 256'd1);
      chk({nm, "_done_at"}, 256'(done_at + 1), 256'd43);
      chk({nm, "_wr0_addr"}, 256'(wr_a[0]), 256'd0);
      chk({nm, "_wr1_addr"}, 256'(wr_a[1]), 256'd1);
      chk({nm, "_wr0_data"}, wr_d[0], e0);
      chk({nm, "_wr1_data"}, wr_d[1], e1);
      chk({nm, "_mem0"}, mem[0], e0);
      chk({nm, "_mem1"}, mem[1], e1);
    end
  endtask

  initial begin
    logic [255:0] w;
    logic [7:0]   sat_exp;
    for (int i = 0; i < 16; i++) mem[i] = rand_word();
    zero_ops();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_busy", 256'(busy), 256'd0);
    chk("reset_done", 256'(done), 256'd0);
    chk("reset_we", 256'(we), 256'd0);
    chk("reset_addr", 256'(addr), 256'd0);
    chk("reset_wdata", write_data, 256'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Basic update: 10 - (16*8 >>> 4) = 2; everything else untouched
    w = rand_word();
    w[7:0] = 8'd10;
    mem[0] = w;
    mem[1] = rand_word();
    w = mem[1];
    zero_ops();
    xr[0] = 9'sd16;
    d2r[0] = 9'sd8;
    do_pass(0, "basic");
    chk("basic_w0", 256'(mem[0][7:0]), 256'd2);
    chk("basic_l2_same", mem[1], w);

    // Saturation corner: -128 - floor(255*-255/16) = 3937
    w = rand_word();
    w[7:0] = 8'h80;
    mem[0] = w;
    zero_ops();
    xr[0] = 9'sd255;
    d2r[0] = -9'sd255;
    do_pass(0, "sat");
`ifdef WEIGHT_UPDATE_SATURATE_EN
    sat_exp = 8'd127;
`else
    sat_exp = 8'd97;
`endif
    chk("sat_w0", 256'(mem[0][7:0]), 256'(sat_exp));

    // Layer-2 indexing: weight 11 = 0 - (32*4 >>> 4) = -8
    w = rand_word();
    w[95:88] = 8'd0;
    mem[1] = w;
    zero_ops();
    vr[5] = 9'sd32;
    d3r[1] = 9'sd4;
    do_pass(0, "l2idx");
    chk("l2idx_w11", 256'(mem[1][95:88]), 256'hF8);
    chk("l2idx_upper", 256'(mem[1][255:96]), 256'(w[255:96]));

    for (int n = 0; n < 6; n++) begin
      mem[0] = rand_word();
      mem[1] = rand_word();
      rand_ops();
      do_pass(0, "rand");
    end

    mem[0] = rand_word();
    mem[1] = rand_word();
    rand_ops();
    do_pass(1, "restart");

    mem[0] = rand_word();
    mem[1] = rand_word();
    rand_ops();
    do_pass(2, "midrst");

    mem[0] = rand_word();
    mem[1] = rand_word();
    rand_ops();
    do_pass(0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_update.md
# weight_update

Training write-back stage downstream of the backpropagation stage. Takes the hidden-layer deltas (`delta_2j`), output-layer deltas (`delta_3j`), inputs `x0..x3` and hidden activations `v0..v5` of one training step. Applies gradient descent, `w <- w - ((a*delta) >>> LR_SHIFT)`, to both weight words in the shared 256-bit weight RAM. It owns the RAM port while busy and returns it idle when done.

## Interface
- `WWIDTH`, 8, width of one signed weight
- `LR_SHIFT`, 4, learning rate as an arithmetic right shift (rate = 2^-LR_SHIFT)
- `ADDR_L0`, 0, RAM address of the layer-1 word (24 weights, 4 inputs x 6 hidden)
- `ADDR_L1`, 1, RAM address of the layer-2 word (12 weights, 6 hidden x 2 outputs)
- `CLK` input 1: single clock; all registers update on rising edge
- `RST` input 1: asynchronous, active-high reset
- `start` input 1: request one update pass; accepted only in IDLE
- `x0..x3` input 9 each: signed network inputs
- `v0..v5` input 9 each: signed hidden activations
- `delta_20..delta_25` input 9 each: signed hidden-layer deltas
- `delta_30, delta_31` input 9 each: signed output-layer deltas
- `busy` output 1: high from start acceptance until done
- `done` output 1: one-cycle pulse at pass completion
- `addr` output 4: RAM address
- `write_data` output 256: RAM write word
- `we` output 1: RAM write enable
- `read_data` input 256: RAM read word, valid one cycle after `addr` is presented

## Operation
- States: IDLE, RD0, WAIT0, UPD0, WR0, RD1, WAIT1, UPD1, WR1, DONE.
- IDLE: if `start`, snapshot all operand inputs into internal registers and go to RD0. Upstream may change inputs afterwards.
- RD0/RD1: drive `addr=ADDR_L0` or `ADDR_L1`, `we=0`.
- WAIT0/WAIT1: capture `read_data` into a 256-bit working buffer.
- UPD0: counter k runs 0..23, one weight per cycle.
  - weight k = buffer bits `[(k+1)*WWIDTH-1 : k*WWIDTH]`
  - neuron j = k/4, input i = k%4
  - operands: `a = x_i`, `d = delta_2j`
- UPD1: counter k runs 0..11.
  - output j = k/6, hidden i = k%6
  - operands: `a = v_i`, `d = delta_3j`
- Arithmetic:
  - 18-bit signed product `a*d`
  - arithmetic shift right by `LR_SHIFT`
  - 19-bit signed subtraction from the sign-extended weight
  - reduce to 8 bits per Configuration
- Buffer bits above the last updated weight are written back unchanged: bits 255:192 in WR0, bits 255:96 in WR1.
- WR0/WR1: `addr` = layer address, `write_data` = buffer, `we=1` for exactly one cycle.
- DONE: `done=1`, `busy=0`; next state IDLE.
- `start` while not IDLE is ignored, not queued.
- `start` held high in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `we=0`, `addr=0`, `write_data=0`, counter 0.
- `start` sampled high in IDLE at edge 0. `busy` is high after edge 0.
- Per-state cycle counts: RD0 1, WAIT0 1, UPD0 24, WR0 1, RD1 1, WAIT1 1, UPD1 12, WR1 1.
- WR0 write commits at edge 27; WR1 write commits at edge 42.
- `done` is high for the cycle following edge 42; `busy` falls with it.
- Total latency: 43 cycles from start to done.
- `we` is high only in the WR0 and WR1 cycles; `addr` holds its value from RD through WR of each layer.
- `RST` mid-pass: immediate return to IDLE with `we=0`, no further writes.
  - Reset before WR0 commit: RAM untouched.
  - Reset between WR0 and WR1: layer-1 word updated, layer-2 word not.

## Configuration
- `WEIGHT_UPDATE_SATURATE_EN` defined: the 19-bit result clamps to [-128, 127].
- Undefined: the result keeps its low 8 bits (two's-complement wrap).

## Test plan
- Basic update:
  - stimulus: layer-1 weight 0 = 10, `x0=16`, `delta_20=8`, `LR_SHIFT=4`, all other operands 0
  - response: WR0 `write_data[7:0]=2`; all other bits equal the read word; WR1 word equals the read word
- Latency/handshake:
  - stimulus: single `start` pulse
  - response: `busy` high for 42 cycles; `we` high exactly at cycles 27 and 42 relative to start; one `done` pulse at cycle 43
- Saturation:
  - stimulus: weight = -128, `x0=255`, `delta_20=-255`
  - response: 127 with macro; 97 without
- Layer-2 indexing:
  - stimulus: `v5=32`, `delta_31=4`, layer-2 weight 11 = 0
  - response: WR1 `write_data[95:88]=0xF8` (-8); bits 255:96 preserved
- Start ignored while busy:
  - stimulus: second `start` at cycle 5 with changed operands
  - response: results use the original snapshot; only one pass runs
- Reset mid-pass:
  - stimulus: `RST` asserted at cycle 30
  - response: `we` drops immediately; layer-1 word updated, layer-2 word unchanged; `busy=0`, `done` never pulses
